// File: rtl/jtframe_dwnld_ctrl_pkg.sv
// Shared definitions for the ioctl download controller: FSM state encoding
// and the default ioctl_index values for ROM and cheat files.
package jtframe_dwnld_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dwnld_state_t;

  localparam logic [7:0] DEF_IDX_ROM   = 8'h00;
  localparam logic [7:0] DEF_IDX_CHEAT = 8'h10;
  localparam logic [7:0] IDX_NVRAM     = 8'hFF;

endpackage

// File: rtl/jtframe_fifo_sync.sv
// Small synchronous FIFO with a combinational head output.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module jtframe_fifo_sync #(
  parameter int W  = 40,
  parameter int AW = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not flushed on reset; clearing the pointers is enough.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == {1'b1, {AW{1'b0}}});
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/jtframe_dwnld_ctrl.sv
// Converts the byte-wide ioctl download stream into 16-bit SDRAM programming
// writes (prog_we/prog_rdy handshake) and steers cheat bytes to their own port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no download in progress
// ST_LOAD  | ioctl_download high, bytes accepted into the FIFO
// ST_DRAIN | download window closed, FIFO still being written out
// ST_DONE  | single cycle: everything written, dwnld_done pulses
module jtframe_dwnld_ctrl
  import jtframe_dwnld_ctrl_pkg::*;
#(
  parameter int         AW        = 22,
  parameter int         FIFO_AW   = 2,
  parameter logic [7:0] IDX_ROM   = DEF_IDX_ROM,
  parameter logic [7:0] IDX_CHEAT = DEF_IDX_CHEAT
) (
  input  logic          i_clk_rom,
  input  logic          i_rst,
  input  logic          i_ioctl_download,
  input  logic [7:0]    i_ioctl_index,
  input  logic [24:0]   i_ioctl_addr,
  input  logic [7:0]    i_ioctl_data,
  input  logic          i_ioctl_wr,
  output logic [AW-1:0] o_prog_addr,
  output logic [15:0]   o_prog_data,
  output logic [1:0]    o_prog_mask,
  output logic          o_prog_we,
  input  logic          i_prog_rdy,
  output logic [7:0]    o_cheat_addr,
  output logic [7:0]    o_cheat_data,
  output logic          o_cheat_we,
  output logic          o_dwnld_busy,
  output logic          o_dwnld_done,
  output logic          o_overflow,
  output logic          o_range_err
);

  localparam int EW = AW + 18;

  dwnld_state_t r_state;
  logic         r_busy;
  logic         r_done;
  logic         r_prog_we;
  logic         r_overflow;
  logic         r_range_err;
  logic         r_cheat_we;

  logic          w_active;
  logic          w_rom_wr;
  logic          w_in_range;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  assign w_active   = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign w_rom_wr   = i_ioctl_wr && (i_ioctl_index == IDX_ROM) && w_active;
  assign w_in_range = ((i_ioctl_addr >> (AW + 1)) == '0);
  assign w_pop      = r_prog_we && i_prog_rdy;
  // A simultaneous pop frees a slot, so a full FIFO can still accept.
  assign w_push     = w_rom_wr && w_in_range && (!w_full || w_pop);
  assign w_entry    = {i_ioctl_addr[AW:1], i_ioctl_data, i_ioctl_data,
                       i_ioctl_addr[0] ? 2'b01 : 2'b10};

  jtframe_fifo_sync #(
    .W  (EW),
    .AW (FIFO_AW)
  ) u_fifo (
    .i_clk   (i_clk_rom),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_entry),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk_rom) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_ioctl_download) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (!i_ioctl_download) begin
            if (w_empty && !w_push) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (i_ioctl_download) begin
            r_state <= ST_LOAD;
          end else if (w_empty && !w_push) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The head stays in the FIFO until acked, so a drain never loses it.
  always_ff @(posedge i_clk_rom) begin
    if (i_rst) begin
      r_prog_we   <= 1'b0;
      o_prog_addr <= '0;
      o_prog_data <= '0;
      o_prog_mask <= '0;
    end else if (w_pop) begin
      r_prog_we <= 1'b0;
    end else if (!r_prog_we && !w_empty) begin
      r_prog_we   <= 1'b1;
      o_prog_addr <= w_head[EW-1:18];
      o_prog_data <= w_head[17:2];
      o_prog_mask <= w_head[1:0];
    end
  end

  always_ff @(posedge i_clk_rom) begin
    if (i_rst) begin
      r_overflow   <= 1'b0;
      r_range_err  <= 1'b0;
      r_cheat_we   <= 1'b0;
      o_cheat_addr <= '0;
      o_cheat_data <= '0;
    end else begin
      if (w_rom_wr && !w_in_range)                  r_range_err <= 1'b1;
      if (w_rom_wr && w_in_range && w_full && !w_pop) r_overflow  <= 1'b1;
      r_cheat_we <= i_ioctl_wr && (i_ioctl_index == IDX_CHEAT) && (r_state == ST_LOAD);
      if (i_ioctl_wr && (i_ioctl_index == IDX_CHEAT) && (r_state == ST_LOAD)) begin
        o_cheat_addr <= i_ioctl_addr[7:0];
        o_cheat_data <= i_ioctl_data;
      end
    end
  end

  assign o_prog_we    = r_prog_we;
  assign o_cheat_we   = r_cheat_we;
  assign o_dwnld_busy = r_busy;
  assign o_dwnld_done = r_done;
  assign o_overflow   = r_overflow;
  assign o_range_err  = r_range_err;

endmodule

// File: tb/tb_jtframe_dwnld_ctrl.sv
// Scoreboard bench for jtframe_dwnld_ctrl: directed downloads push expected
// SDRAM/cheat writes into queues, a monitor pops and compares on each handshake.
module tb_jtframe_dwnld_ctrl;

  localparam int AW = 22;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          download;
  logic [7:0]    index;
  logic [24:0]   ioaddr;
  logic [7:0]    iodata;
  logic          iowr;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic          prog_rdy;
  logic [7:0]    cheat_addr;
  logic [7:0]    cheat_data;
  logic          cheat_we;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          range_err;

  always #5 clk = ~clk;

  jtframe_dwnld_ctrl #(
    .AW        (AW),
    .FIFO_AW   (2),
    .IDX_ROM   (8'h00),
    .IDX_CHEAT (8'h10)
  ) dut (
    .i_clk_rom        (clk),
    .i_rst            (rst),
    .i_ioctl_download (download),
    .i_ioctl_index    (index),
    .i_ioctl_addr     (ioaddr),
    .i_ioctl_data     (iodata),
    .i_ioctl_wr       (iowr),
    .o_prog_addr      (prog_addr),
    .o_prog_data      (prog_data),
    .o_prog_mask      (prog_mask),
    .o_prog_we        (prog_we),
    .i_prog_rdy       (prog_rdy),
    .o_cheat_addr     (cheat_addr),
    .o_cheat_data     (cheat_data),
    .o_cheat_we       (cheat_we),
    .o_dwnld_busy     (busy),
    .o_dwnld_done     (done),
    .o_overflow       (overflow),
    .o_range_err      (range_err)
  );

  wr_t         exp_q[$];
  logic [15:0] cheat_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  wr_cnt = 0;
  int  cheat_cnt = 0;
  int  done_cnt = 0;
  bit  seen_we = 0;
  bit  rdy_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // SDRAM model: ack two cycles after prog_we is seen
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    prog_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (prog_rdy) begin
        prog_rdy = 1'b0;
        wait_cnt = 0;
      end else if (rdy_en && prog_we) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          prog_rdy = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    wr_t         e;
    logic [15:0] c;
    forever begin
      @(negedge clk);
      #1;
      if (prog_we) seen_we = 1;
      if (done) done_cnt++;
      if (prog_we && prog_rdy) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL prog_write: got unexpected write addr %0h data %0h mask %0b",
                   prog_addr, prog_data, prog_mask);
        end else begin
          e = exp_q.pop_front();
          chk("prog_write", {prog_addr, prog_data, prog_mask}, e);
        end
      end
      if (cheat_we) begin
        cheat_cnt++;
        if (cheat_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL cheat_write: got unexpected write addr %0h data %0h",
                   cheat_addr, cheat_data);
        end else begin
          c = cheat_q.pop_front();
          chk("cheat_write", {cheat_addr, cheat_data}, c);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    download = 1'b0;
    iowr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cheat_q.delete();
    wr_cnt = 0;
    cheat_cnt = 0;
    done_cnt = 0;
    seen_we = 0;
  endtask

  task automatic send_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    index  = idx;
    ioaddr = a;
    iodata = d;
    iowr   = 1'b1;
    @(negedge clk);
    iowr   = 1'b0;
  endtask

  task automatic push_exp(input int word, input logic [7:0] d, input logic [1:0] m);
    wr_t e;
    e.addr = word[AW-1:0];
    e.data = {d, d};
    e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done) got = 1;
    end
    chk(name, got, 1);
  endtask

  initial begin
    int          word_tbl[8];
    logic [1:0]  mask_tbl[8];
    bit          early_idle;
    bit          got;

    word_tbl = '{0, 0, 1, 1, 2, 2, 3, 3};
    mask_tbl = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    rst = 1'b1;
    download = 1'b0;
    index = 8'h00;
    ioaddr = '0;
    iodata = '0;
    iowr = 1'b0;

    // 1: eight ROM bytes at 0..7, paced slower than the drain
    do_reset();
    #1;
    chk("reset_flags", {prog_we, busy, done, overflow, range_err, cheat_we}, 0);
    chk("reset_prog_addr", prog_addr, 0);
    rdy_en = 1;
    download = 1'b1;
    @(negedge clk);
    #1;
    chk("busy_on_start", busy, 1);
    for (int i = 0; i < 8; i++) begin
      push_exp(word_tbl[i], 8'h10 + 8'(i), mask_tbl[i]);
      send_byte(8'h00, 25'(i), 8'h10 + 8'(i));
      repeat (2) @(negedge clk);
    end
    download = 1'b0;
    wait_done("t1_done");
    repeat (4) @(negedge clk);
    chk("t1_writes", wr_cnt, 8);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_overflow", overflow, 0);
    chk("t1_busy_after", busy, 0);

    // 2: no acks, six bytes into a four-deep FIFO
    do_reset();
    rdy_en = 0;
    download = 1'b1;
    @(negedge clk);
    push_exp(32'h80, 8'hB0, 2'b10);
    push_exp(32'h80, 8'hB1, 2'b01);
    push_exp(32'h81, 8'hB2, 2'b10);
    push_exp(32'h81, 8'hB3, 2'b01);
    for (int i = 0; i < 6; i++) send_byte(8'h00, 25'h100 + 25'(i), 8'hB0 + 8'(i));
    repeat (2) @(negedge clk);
    #1;
    chk("t2_overflow", overflow, 1);
    chk("t2_no_writes_yet", wr_cnt, 0);
    chk("t2_we_waiting", prog_we, 1);
    rdy_en = 1;
    download = 1'b0;
    wait_done("t2_done");
    repeat (4) @(negedge clk);
    chk("t2_writes", wr_cnt, 4);
    chk("t2_queue_left", exp_q.size(), 0);

    // 3: window closes with three entries queued
    do_reset();
    rdy_en = 0;
    download = 1'b1;
    @(negedge clk);
    push_exp(32'h10, 8'hC0, 2'b10);
    push_exp(32'h10, 8'hC1, 2'b01);
    push_exp(32'h11, 8'hC2, 2'b10);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 25'h20 + 25'(i), 8'hC0 + 8'(i));
    download = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t3_busy_drain", busy, 1);
    chk("t3_no_done", done_cnt, 0);
    rdy_en = 1;
    early_idle = 0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done) got = 1;
      else if (!busy) early_idle = 1;
    end
    chk("t3_done_seen", got, 1);
    chk("t3_writes_at_done", wr_cnt, 3);
    chk("t3_busy_held", early_idle, 0);
    @(negedge clk);
    #1;
    chk("t3_done_one_cycle", {done, busy}, 0);

    // 4: out-of-range byte dropped, top in-range byte accepted
    do_reset();
    rdy_en = 1;
    download = 1'b1;
    @(negedge clk);
    send_byte(8'h00, 25'h80_0000, 8'h5A);
    repeat (8) @(negedge clk);
    #1;
    chk("t4_no_we", seen_we, 0);
    chk("t4_range_err", range_err, 1);
    chk("t4_overflow", overflow, 0);
    push_exp(32'h3F_FFFF, 8'h6B, 2'b01);
    send_byte(8'h00, 25'h7F_FFFF, 8'h6B);
    download = 1'b0;
    wait_done("t4_done");
    chk("t4_writes", wr_cnt, 1);

    // 5: cheat byte bypasses the FIFO; NVRAM index ignored
    do_reset();
    rdy_en = 1;
    download = 1'b1;
    @(negedge clk);
    cheat_q.push_back({8'h05, 8'hA5});
    send_byte(8'h10, 25'h5, 8'hA5);
    send_byte(8'hFF, 25'h6, 8'h3C);
    repeat (6) @(negedge clk);
    chk("t5_cheat_cycles", cheat_cnt, 1);
    chk("t5_no_we", seen_we, 0);
    chk("t5_cheat_left", cheat_q.size(), 0);
    download = 1'b0;
    wait_done("t5_done");

    // 6: reset while a write is pending with two entries queued
    do_reset();
    rdy_en = 0;
    download = 1'b1;
    @(negedge clk);
    send_byte(8'h00, 25'h100_0000, 8'h11);
    send_byte(8'h00, 25'h40, 8'h22);
    send_byte(8'h00, 25'h41, 8'h33);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (prog_we) got = 1;
    end
    chk("t6_we_pending", got, 1);
    chk("t6_range_err_set", range_err, 1);
    rst = 1'b1;
    download = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_we_dropped", prog_we, 0);
    chk("t6_flags_cleared", {range_err, overflow, busy}, 0);
    rst = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    done_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_idle_after_rst", {prog_we, busy}, 0);
    rdy_en = 1;
    download = 1'b1;
    @(negedge clk);
    push_exp(32'h1, 8'h77, 2'b01);
    send_byte(8'h00, 25'h3, 8'h77);
    download = 1'b0;
    wait_done("t6_done");
    repeat (3) @(negedge clk);
    chk("t6_writes", wr_cnt, 1);
    chk("t6_done_pulses", done_cnt, 1);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
